// File: rtl/jtframe_joy_serial.sv
// Serial joystick/keypad reader for a chain of parallel-load shift registers (74HC165-style).
// Optional per-bit two-frame debounce when JTFRAME_JOY_DEBOUNCE_EN is defined.
module jtframe_joy_serial #(
   parameter int unsigned PLAYERS    = 2,
   parameter int unsigned BUTTONS    = 12,
   parameter int unsigned CLKDIV     = 4,
   parameter int unsigned GAP        = 8,
   parameter bit          ACTIVE_LOW = 1'b1
) (
   input  logic                         clk_sys,
   input  logic                         rst,
   input  logic                         en,
   input  logic                         JOY_DATA,
   output logic                         JOY_CLK,
   output logic                         JOY_LOAD,
   output logic [PLAYERS*BUTTONS-1:0]   joy_bits,
   output logic                         joy_valid,
   output logic                         frame_done
);

   localparam int unsigned TOTAL = PLAYERS * BUTTONS;
   localparam int unsigned CW    = $clog2(TOTAL) + 1;
   localparam int unsigned DW    = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
   localparam int unsigned GW    = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [TOTAL-1:0] INV_MASK = ACTIVE_LOW ? {TOTAL{1'b1}} : {TOTAL{1'b0}};

   typedef enum logic [2:0] {
      ST_IDLE, ST_LOAD, ST_SHIFT_LO, ST_SHIFT_HI, ST_DONE
   } state_e;

   state_e             state_q, state_d;
   logic [DW-1:0]      div_q, div_d;
   logic [GW-1:0]      gap_q, gap_d;
   logic               gap_exp_q, gap_exp_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [TOTAL-1:0]   shift_q, shift_d;
   logic [TOTAL-1:0]   bits_q, bits_d;
   logic               clk_q, clk_d;
   logic               load_q, load_d;
   logic               valid_q, valid_d;
   logic               done_q, done_d;
   logic               tick, expired, last_bit;
   logic [TOTAL-1:0]   raw;
`ifdef JTFRAME_JOY_DEBOUNCE_EN
   logic [TOTAL-1:0]   prev_q, prev_d;
   logic               primed_q, primed_d;
   logic [TOTAL-1:0]   same;
`endif

   assign tick     = (div_q == DW'(CLKDIV - 1));
   assign expired  = gap_exp_q || (gap_q == '0);
   assign last_bit = (cnt_q == CW'(TOTAL - 1));
   assign raw      = shift_q ^ INV_MASK;

   // State register
   always_ff @(posedge clk_sys) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:     if (tick && en && expired) state_d = ST_LOAD;
         ST_LOAD:     if (tick) state_d = ST_SHIFT_LO;
         ST_SHIFT_LO: if (tick) state_d = ST_SHIFT_HI;
         ST_SHIFT_HI: if (tick) state_d = last_bit ? ST_DONE : ST_SHIFT_LO;
         ST_DONE:     state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   // Output and datapath next values; pins follow the next state so they stay registered
   always_comb begin
      clk_d     = (state_d == ST_SHIFT_HI);
      load_d    = (state_d != ST_LOAD);
      div_d     = tick ? '0 : div_q + DW'(1);
      gap_d     = gap_q;
      gap_exp_d = gap_exp_q;
      cnt_d     = cnt_q;
      shift_d   = shift_q;
      bits_d    = bits_q;
      valid_d   = valid_q;
      done_d    = 1'b0;
`ifdef JTFRAME_JOY_DEBOUNCE_EN
      prev_d    = prev_q;
      primed_d  = primed_q;
      same      = ~(raw ^ prev_q);
`endif
      case (state_q)
         ST_IDLE: begin
            if (!en)                     gap_exp_d = 1'b1;
            else if (tick && !expired)   gap_d     = gap_q - GW'(1);
         end
         ST_LOAD:     if (tick) cnt_d = '0;
         ST_SHIFT_LO: if (tick) shift_d = {shift_q[TOTAL-2:0], JOY_DATA};
         ST_SHIFT_HI: if (tick && !last_bit) cnt_d = cnt_q + CW'(1);
         ST_DONE: begin
            // Divider restarts so the gap is a whole number of ticks after DONE
            div_d     = '0;
            gap_d     = GW'(GAP - 1);
            gap_exp_d = 1'b0;
            done_d    = 1'b1;
`ifdef JTFRAME_JOY_DEBOUNCE_EN
            if (primed_q) begin
               bits_d  = (raw & same) | (bits_q & ~same);
               valid_d = 1'b1;
            end
            prev_d   = raw;
            primed_d = 1'b1;
`else
            bits_d  = raw;
            valid_d = 1'b1;
`endif
         end
         default: ;
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clk_sys) begin
      if (rst) begin
         div_q     <= '0;
         gap_q     <= GW'(GAP - 1);
         gap_exp_q <= 1'b1;
         cnt_q     <= '0;
         shift_q   <= '0;
         bits_q    <= '0;
         clk_q     <= 1'b0;
         load_q    <= 1'b1;
         valid_q   <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         div_q     <= div_d;
         gap_q     <= gap_d;
         gap_exp_q <= gap_exp_d;
         cnt_q     <= cnt_d;
         shift_q   <= shift_d;
         bits_q    <= bits_d;
         clk_q     <= clk_d;
         load_q    <= load_d;
         valid_q   <= valid_d;
         done_q    <= done_d;
      end
   end

`ifdef JTFRAME_JOY_DEBOUNCE_EN
   always_ff @(posedge clk_sys) begin
      if (rst) begin
         prev_q   <= '0;
         primed_q <= 1'b0;
      end else begin
         prev_q   <= prev_d;
         primed_q <= primed_d;
      end
   end
`endif

   assign JOY_CLK    = clk_q;
   assign JOY_LOAD   = load_q;
   assign joy_bits   = bits_q;
   assign joy_valid  = valid_q;
   assign frame_done = done_q;

endmodule

// File: tb/tb_jtframe_joy_serial.sv
// Bench for jtframe_joy_serial: two instances (active-low and active-high chains) in lockstep,
// each fed by a 74HC165 chain model; frames are checked by a scoreboard on frame_done.
module tb_jtframe_joy_serial;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, en;
   logic        data_a, data_b;
   logic        jclk_a, jload_a, valid_a, done_a;
   logic        jclk_b, jload_b, valid_b, done_b;
   logic [23:0] bits_a, bits_b;

   jtframe_joy_serial #(.PLAYERS(2), .BUTTONS(12), .CLKDIV(4), .GAP(8), .ACTIVE_LOW(1'b1)) u_dut_a (
      .clk_sys(clk), .rst(rst), .en(en), .JOY_DATA(data_a), .JOY_CLK(jclk_a), .JOY_LOAD(jload_a),
      .joy_bits(bits_a), .joy_valid(valid_a), .frame_done(done_a));

   jtframe_joy_serial #(.PLAYERS(2), .BUTTONS(12), .CLKDIV(4), .GAP(8), .ACTIVE_LOW(1'b0)) u_dut_b (
      .clk_sys(clk), .rst(rst), .en(en), .JOY_DATA(data_b), .JOY_CLK(jclk_b), .JOY_LOAD(jload_b),
      .joy_bits(bits_b), .joy_valid(valid_b), .frame_done(done_b));

   // Shift-register chain models: parallel load while LOAD low, shift on JOY_CLK rise
   logic [23:0] pat_a = '0, pat_b = '0, chain_a = '0, chain_b = '0;
   logic        jclk_a_d = 1'b0, jclk_b_d = 1'b0;
   always @(posedge clk) begin
      if (!jload_a)                chain_a <= pat_a;
      else if (jclk_a && !jclk_a_d) chain_a <= chain_a << 1;
      if (!jload_b)                chain_b <= pat_b;
      else if (jclk_b && !jclk_b_d) chain_b <= chain_b << 1;
      jclk_a_d <= jclk_a;
      jclk_b_d <= jclk_b;
   end
   assign data_a = chain_a[23];
   assign data_b = chain_b[23];

   typedef struct packed {
      logic [23:0] a;
      logic [23:0] b;
      logic        va;
      logic        vb;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   logic [23:0] m_bits_a, m_bits_b;
   logic        m_valid;
`ifdef JTFRAME_JOY_DEBOUNCE_EN
   logic [23:0] m_prev_a, m_prev_b;
   logic        m_primed;
`endif

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      m_bits_a = '0;
      m_bits_b = '0;
      m_valid  = 1'b0;
`ifdef JTFRAME_JOY_DEBOUNCE_EN
      m_prev_a = '0;
      m_prev_b = '0;
      m_primed = 1'b0;
`endif
   endtask

   // Set chain patterns for the next frame and queue the expected latched result
   task automatic push_frame(input logic [23:0] pa, input logic [23:0] pb);
      logic [23:0] ra, rb;
      exp_t        e;
      pat_a = pa;
      pat_b = pb;
      ra    = ~pa;
      rb    = pb;
`ifdef JTFRAME_JOY_DEBOUNCE_EN
      if (m_primed) begin
         m_bits_a = (ra & ~(ra ^ m_prev_a)) | (m_bits_a & (ra ^ m_prev_a));
         m_bits_b = (rb & ~(rb ^ m_prev_b)) | (m_bits_b & (rb ^ m_prev_b));
         m_valid  = 1'b1;
      end
      m_prev_a = ra;
      m_prev_b = rb;
      m_primed = 1'b1;
`else
      m_bits_a = ra;
      m_bits_b = rb;
      m_valid  = 1'b1;
`endif
      e.a  = m_bits_a;
      e.b  = m_bits_b;
      e.va = m_valid;
      e.vb = m_valid;
      sb_q.push_back(e);
   endtask

   // Monitor: every frame_done must match the next queued expectation
   exp_t mon_e;
   always @(negedge clk) begin
      if (done_a === 1'b1 || done_b === 1'b1) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame_done: got done_a=%0b done_b=%0b, expected no pulse", done_a, done_b);
         end else begin
            mon_e = sb_q.pop_front();
            check("sb_bits_a",  64'(bits_a),  64'(mon_e.a));
            check("sb_bits_b",  64'(bits_b),  64'(mon_e.b));
            check("sb_valid_a", 64'(valid_a), 64'(mon_e.va));
            check("sb_valid_b", 64'(valid_b), 64'(mon_e.vb));
            check("sb_done_sync", 64'({done_a, done_b}), 64'(2'b11));
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input string nm);
      bit seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         cyc();
         if (done_a) seen = 1'b1;
      end
      check(nm, 64'(seen), 64'(1));
   endtask

   task automatic wait_rises(input int n, input string nm);
      int   r = 0;
      logic p = jclk_a;
      for (int i = 0; i < 600 && r < n; i++) begin
         cyc();
         if (jclk_a && !p) r++;
         p = jclk_a;
      end
      check(nm, 64'(r), 64'(n));
   endtask

   initial begin
      int   n, hi, rises;
      logic prev;
      rst = 1'b1;
      en  = 1'b1;
      model_reset();
      push_frame(24'hFFFFFE, 24'hA5C3F0);
      repeat (3) cyc();
      check("rst_jclk",  64'(jclk_a),  64'(0));
      check("rst_jload", 64'(jload_a), 64'(1));
      check("rst_bits",  64'(bits_a),  64'(0));
      check("rst_valid", 64'(valid_a), 64'(0));
      check("rst_done",  64'(done_a),  64'(0));

      // LOAD must be low for exactly cycles 4..7 after release
      rst = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         cyc();
         check("load_timing", 64'(jload_a), 64'((k >= 4 && k <= 7) ? 0 : 1));
      end

      hi = 0; rises = 0; prev = jclk_a;
      for (int i = 0; i < 300 && !done_a; i++) begin
         cyc();
         if (jclk_a) hi++;
         if (jclk_a && !prev) rises++;
         prev = jclk_a;
      end
      check("frame1_done",    64'(done_a), 64'(1));
      check("frame1_pulses",  64'(rises),  64'(24));
      check("frame1_hi_cyc",  64'(hi),     64'(96));
`ifdef JTFRAME_JOY_DEBOUNCE_EN
      check("f1_bits_a",  64'(bits_a),  64'(0));
      check("f1_valid_a", 64'(valid_a), 64'(0));
`else
      check("f1_bits_a",  64'(bits_a),  64'(24'h000001));
      check("f1_bits_b",  64'(bits_b),  64'(24'hA5C3F0));
      check("f1_p2_b",    64'(bits_b[23:12]), 64'(12'hA5C));
      check("f1_valid_a", 64'(valid_a), 64'(1));
`endif
      push_frame(24'h123456, 24'h000FFF);

      n = 0;
      for (int i = 0; i < 100; i++) begin
         cyc();
         n++;
         if (!jload_a) break;
      end
      check("gap_cycles", 64'(n), 64'(32));

      // Drop en mid-frame: frame completes, then scanning stops
      wait_rises(3, "f2_rises");
      en = 1'b0;
      wait_done("frame2_done");
      push_frame(24'h0F0F0F, 24'h3C3C3C);
      n = 0;
      repeat (120) begin
         cyc();
         if (!jload_a) n++;
      end
      check("idle_no_load", 64'(n), 64'(0));
      en = 1'b1;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         cyc();
         n++;
         if (!jload_a) break;
      end
      check("resume_latency", 64'(n >= 1 && n <= 4), 64'(1));
      wait_done("frame3_done");

      // Reset mid-frame: outputs clear next cycle, aborted frame never reports
      wait_rises(5, "f4_rises");
      rst = 1'b1;
      model_reset();
      cyc();
      check("abort_jclk",  64'(jclk_a),  64'(0));
      check("abort_jload", 64'(jload_a), 64'(1));
      check("abort_bits",  64'(bits_a),  64'(0));
      check("abort_bitsb", 64'(bits_b),  64'(0));
      check("abort_valid", 64'(valid_a), 64'(0));
      check("abort_done",  64'(done_a),  64'(0));
      repeat (3) cyc();

      push_frame(24'hFFFF00, 24'h000001);
      rst = 1'b0;
      wait_done("frame4_done");
`ifdef JTFRAME_JOY_DEBOUNCE_EN
      check("f4_bits_b",  64'(bits_b),  64'(0));
      check("f4_valid_b", 64'(valid_b), 64'(0));
`else
      check("f4_bits_b",  64'(bits_b),  64'(24'h000001));
      check("f4_bits_a",  64'(bits_a),  64'(24'h0000FF));
`endif
      push_frame(24'hFFFF00, 24'h000003);
      wait_done("frame5_done");
`ifdef JTFRAME_JOY_DEBOUNCE_EN
      check("f5_bits_b",  64'(bits_b),  64'(24'h000001));
      check("f5_valid_b", 64'(valid_b), 64'(1));
`else
      check("f5_bits_b",  64'(bits_b),  64'(24'h000003));
`endif
      push_frame(24'hF0FF00, 24'h000003);
      wait_done("frame6_done");
      en = 1'b0;
      check("f6_bits_b", 64'(bits_b), 64'(24'h000003));

      repeat (300) cyc();
      check("sb_empty", 64'(sb_q.size()), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
